stage2_execute: RTL and testbench
=================================

Name: stage2_execute

Overview:
- Execute stage that consumes stage 1 outputs: aluin1, aluin2, operation_out, opselect_out, shift_number, enable_arith, enable_shift and enable_ex.
- Produces a registered result with status flags and a one-cycle valid pulse for writeback.
- Arithmetic/logic and load-format operations complete in 1 cycle.
- Shifts run serially, one bit per cycle. While a shift is in progress the block drives stall_out so stage 1 holds its outputs.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the half-word and byte operations assume it.
- SHAMT_W, 5, width of the shift count.

Ports:
- CLOCK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- enable_ex  input  1  stage qualifier; an operation is accepted only when this is 1
- enable_arith  input  1  arith/logic/load request
- enable_shift  input  1  shift request
- opselect  input  3  001 = arith/logic, 101 = mem read, 000 = shift
- operation  input  3  sub-operation code
- aluin1  input  32  operand A
- aluin2  input  32  operand B
- shift_number  input  5  shift amount
- mem_data_read_in  input  32  memory read data
- aluout  output  32  registered result
- carry  output  1  registered carry/borrow/shifted-out bit
- overflow  output  1  registered signed overflow (ADD and SUB only)
- valid_out  output  1  one-cycle pulse when aluout/carry/overflow update
- stall_out  output  1  combinational; 1 while the FSM is in SHIFT

Behaviour:
- Reset: aluout=0, carry=0, overflow=0, valid_out=0, FSM=IDLE, counter=0. Reset wins over every other event, including mid-shift: a pending shift is discarded and no valid_out is produced for it.
- Accept rule: in IDLE at a rising edge with enable_ex=1, and enable_arith=1 or enable_shift=1.
  - If both request lines are 1, enable_arith has priority.
  - In SHIFT, all inputs are ignored.
- valid_out defaults to 0 every cycle. It is 1 for exactly one cycle after each completing edge. aluout, carry and overflow hold their values between results.
- Arith path (enable_arith, opselect=001), latency 1 edge:
  - ADD: {carry,aluout} = A+B; overflow = signed overflow.
  - HADD: sum = A[15:0]+B[15:0]; aluout = sign-extended sum[15:0]; carry = bit16.
  - SUB: aluout = A-B; carry = 1 when A<B unsigned; overflow = signed overflow.
  - NOT: aluout = ~B.
  - AND, OR, XOR: bitwise on A and B.
  - LHG: aluout = {B[15:0], 16'h0}.
  - carry=0 for NOT, AND, OR, XOR, LHG; overflow=0 for every operation except ADD and SUB.
- Load path (enable_arith, opselect=101), latency 1 edge:
  - 000: sign-extend mem[7:0].
  - 100: zero-extend mem[7:0].
  - 001: sign-extend mem[15:0].
  - 101: zero-extend mem[15:0].
  - 011: mem[31:0].
  - Any other code: aluout=0.
  - carry=0 and overflow=0 for all load codes.
- enable_arith with any other opselect: aluout=0, carry=0, overflow=0, valid_out pulses.
- Shift path (enable_shift, opselect=000):
  - FSM states: IDLE, SHIFT.
  - On the accept edge: acc=A, cnt=shift_number, op latched.
  - If shift_number=0: stay in IDLE, aluout=A, carry=0, valid_out pulses (latency 1).
  - Otherwise go to SHIFT. Each edge in SHIFT shifts acc by one bit and decrements cnt.
  - The edge with cnt==1 writes the final acc to aluout, sets carry to the last bit shifted out, pulses valid_out and returns to IDLE.
  - Result latency is N edges after the accept edge. stall_out is high for N cycles.
  - Operations: 000 = logical left; 001 = arithmetic left (same as 000); 010 = logical right (fill 0); 011 = arithmetic right (fill A[31]).
  - Any other shift code: aluout=A, carry=0, single-cycle completion.
  - overflow=0 for all shifts.
- Back-to-back accepts in consecutive IDLE cycles are allowed: one result is produced per cycle.

Test Plan:
- Reset, then ADD with A=32'hFFFF_FFFF, B=1 -> the edge after accept gives aluout=0, carry=1, overflow=0, valid_out high for 1 cycle. Then SUB with A=32'h8000_0000, B=1 -> aluout=32'h7FFF_FFFF, overflow=1, carry=0.
- HADD with A=32'h0000_7FFF, B=1 -> aluout=32'hFFFF_8000, carry=0. LHG with B=32'h1234_ABCD -> aluout=32'hABCD_0000.
- Loads with mem=32'h1234_80F0: 000 -> FFFF_FFF0; 100 -> 0000_00F0; 001 -> FFFF_80F0; 101 -> 0000_80F0; 011 -> 1234_80F0.
- Arithmetic right shift with A=32'h8000_0010, N=5:
  - stall_out high for 5 cycles, inputs changed during the stall are ignored.
  - Then aluout=32'hFC00_0000, carry=1, single valid_out pulse.
  - Also N=0 -> aluout=A on the next cycle, stall_out never high.
- Logical left shift with A=32'hC000_0001, N=3; assert RESET on the 2nd SHIFT cycle -> all outputs 0, FSM in IDLE, no valid_out. A new ADD (A=2, B=3) accepted after reset -> aluout=5.
- enable_arith and enable_shift both 1 with opselect=001, ADD, A=2, B=3 -> arith result aluout=5 in 1 cycle, no stall.

Source files
------------

// File: rtl/stage2_execute_if.sv
// rtl/stage2_execute_if.sv - stage 1 to execute-stage bundle plus writeback result
interface stage2_execute_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               enable_ex;
  logic               enable_arith;
  logic               enable_shift;
  logic [2:0]         opselect;
  logic [2:0]         operation;
  logic [WIDTH-1:0]   aluin1;
  logic [WIDTH-1:0]   aluin2;
  logic [SHAMT_W-1:0] shift_number;
  logic [WIDTH-1:0]   mem_data_read_in;
  logic [WIDTH-1:0]   aluout;
  logic               carry;
  logic               overflow;
  logic               valid_out;
  logic               stall_out;

  modport master (
    output enable_ex, enable_arith, enable_shift, opselect, operation,
           aluin1, aluin2, shift_number, mem_data_read_in,
    input  aluout, carry, overflow, valid_out, stall_out
  );

  modport slave (
    input  enable_ex, enable_arith, enable_shift, opselect, operation,
           aluin1, aluin2, shift_number, mem_data_read_in,
    output aluout, carry, overflow, valid_out, stall_out
  );
endinterface

// File: rtl/stage2_execute.sv
// rtl/stage2_execute.sv - execute stage: 1-cycle arith/logic/load, serial bit-per-cycle shifter
module stage2_execute #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            CLOCK,
  input  logic            RESET,
  stage2_execute_if.slave ex
);
  localparam logic [2:0] SEL_ARITH = 3'b001;
  localparam logic [2:0] SEL_LOAD  = 3'b101;
  localparam logic [2:0] SEL_SHIFT = 3'b000;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_HADD = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_LHG  = 3'd7;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         sop_q, sop_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_res;
  logic [16:0]        hadd_full;
  logic [WIDTH-1:0]   a_res;
  logic               a_carry;
  logic               a_ovf;
  logic [WIDTH-1:0]   step_acc;
  logic               step_bit;

  assign add_full  = {1'b0, ex.aluin1} + {1'b0, ex.aluin2};
  assign sub_res   = ex.aluin1 - ex.aluin2;
  assign hadd_full = {1'b0, ex.aluin1[15:0]} + {1'b0, ex.aluin2[15:0]};

  // Single-cycle result for the enable_arith request (arith, load, or unknown opselect -> 0)
  always_comb begin
    a_res   = '0;
    a_carry = 1'b0;
    a_ovf   = 1'b0;
    if (ex.opselect == SEL_ARITH) begin
      case (ex.operation)
        OP_ADD: begin
          a_res   = add_full[WIDTH-1:0];
          a_carry = add_full[WIDTH];
          a_ovf   = (ex.aluin1[WIDTH-1] == ex.aluin2[WIDTH-1]) &&
                    (add_full[WIDTH-1] != ex.aluin1[WIDTH-1]);
        end
        OP_HADD: begin
          a_res   = {{16{hadd_full[15]}}, hadd_full[15:0]};
          a_carry = hadd_full[16];
        end
        OP_SUB: begin
          a_res   = sub_res;
          a_carry = (ex.aluin1 < ex.aluin2);
          a_ovf   = (ex.aluin1[WIDTH-1] != ex.aluin2[WIDTH-1]) &&
                    (sub_res[WIDTH-1] != ex.aluin1[WIDTH-1]);
        end
        OP_NOT:  a_res = ~ex.aluin2;
        OP_AND:  a_res = ex.aluin1 & ex.aluin2;
        OP_OR:   a_res = ex.aluin1 | ex.aluin2;
        OP_XOR:  a_res = ex.aluin1 ^ ex.aluin2;
        OP_LHG:  a_res = {ex.aluin2[15:0], 16'h0000};
        default: a_res = '0;
      endcase
    end else if (ex.opselect == SEL_LOAD) begin
      case (ex.operation)
        3'b000:  a_res = {{24{ex.mem_data_read_in[7]}}, ex.mem_data_read_in[7:0]};
        3'b100:  a_res = {24'h0, ex.mem_data_read_in[7:0]};
        3'b001:  a_res = {{16{ex.mem_data_read_in[15]}}, ex.mem_data_read_in[15:0]};
        3'b101:  a_res = {16'h0, ex.mem_data_read_in[15:0]};
        3'b011:  a_res = ex.mem_data_read_in;
        default: a_res = '0;
      endcase
    end
  end

  // One shift step; sop_q[1] selects right, sop_q[0] selects sign fill on right shifts
  always_comb begin
    if (!sop_q[1]) begin
      step_bit = acc_q[WIDTH-1];
      step_acc = {acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_bit = acc_q[0];
      step_acc = {sop_q[0] & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sop_d      = sop_q;
    aluout_d   = aluout_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex.enable_ex && ex.enable_arith) begin
          aluout_d   = a_res;
          carry_d    = a_carry;
          overflow_d = a_ovf;
          valid_d    = 1'b1;
        end else if (ex.enable_ex && ex.enable_shift) begin
          acc_d      = ex.aluin1;
          cnt_d      = ex.shift_number;
          sop_d      = ex.operation;
          overflow_d = 1'b0;
          carry_d    = 1'b0;
          if (ex.opselect != SEL_SHIFT) begin
            aluout_d = '0;
            valid_d  = 1'b1;
          end else if (ex.shift_number == '0 || ex.operation[2]) begin
            aluout_d = ex.aluin1;
            valid_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = step_acc;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          aluout_d = step_acc;
          carry_d  = step_bit;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      sop_q      <= '0;
      aluout_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sop_q      <= sop_d;
      aluout_q   <= aluout_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign ex.aluout    = aluout_q;
  assign ex.carry     = carry_q;
  assign ex.overflow  = overflow_q;
  assign ex.valid_out = valid_q;
  assign ex.stall_out = (state_q == SHIFT);
endmodule

// File: tb/tb_stage2_execute.sv
// tb/tb_stage2_execute.sv - directed self-checking bench for stage2_execute
module tb_stage2_execute;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  stage2_execute_if bus ();

  stage2_execute dut (
    .CLOCK (clk),
    .RESET (rst),
    .ex    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.enable_ex    = 1'b0;
    bus.enable_arith = 1'b0;
    bus.enable_shift = 1'b0;
  endtask

  task automatic issue(input logic ea, input logic es, input logic [2:0] sel,
                       input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] n);
    bus.enable_ex    = 1'b1;
    bus.enable_arith = ea;
    bus.enable_shift = es;
    bus.opselect     = sel;
    bus.operation    = op;
    bus.aluin1       = a;
    bus.aluin2       = b;
    bus.shift_number = n;
  endtask

  logic [2:0]  lg_op  [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] lg_exp [4] = '{32'hF00F_FF00, 32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB};
  logic [2:0]  ld_op  [6] = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FFF0, 32'h0, 32'h0000_00F0, 32'hFFFF_80F0,
                              32'h0000_80F0, 32'h1234_80F0};

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    idle();
    bus.opselect = 3'b000;
    bus.operation = 3'b000;
    bus.aluin1 = '0;
    bus.aluin2 = '0;
    bus.shift_number = '0;
    bus.mem_data_read_in = 32'h1234_80F0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_aluout", bus.aluout, 32'h0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_stall", 32'(bus.stall_out), 32'd0);

    issue(1'b1, 1'b0, 3'b001, 3'd0, 32'hFFFF_FFFF, 32'h1, 5'd0);
    tick();
    idle();
    chk("add_aluout", bus.aluout, 32'h0);
    chk("add_carry", 32'(bus.carry), 32'd1);
    chk("add_ovf", 32'(bus.overflow), 32'd0);
    chk("add_valid", 32'(bus.valid_out), 32'd1);
    tick();
    chk("add_valid_drop", 32'(bus.valid_out), 32'd0);
    chk("add_hold", 32'(bus.carry), 32'd1);

    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 3'b001, lg_op[i], 32'hF0F0_1234, 32'h0FF0_00FF, 5'd0);
      tick();
      chk("logic_aluout", bus.aluout, lg_exp[i]);
      chk("logic_carry", 32'(bus.carry), 32'd0);
    end
    idle();

    issue(1'b1, 1'b0, 3'b001, 3'd2, 32'h8000_0000, 32'h1, 5'd0);
    tick();
    chk("sub_aluout", bus.aluout, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(bus.overflow), 32'd1);
    chk("sub_carry", 32'(bus.carry), 32'd0);
    issue(1'b1, 1'b0, 3'b001, 3'd2, 32'h1, 32'h2, 5'd0);
    tick();
    chk("sub_borrow_aluout", bus.aluout, 32'hFFFF_FFFF);
    chk("sub_borrow_carry", 32'(bus.carry), 32'd1);
    chk("sub_borrow_ovf", 32'(bus.overflow), 32'd0);

    issue(1'b1, 1'b0, 3'b001, 3'd1, 32'h0000_7FFF, 32'h1, 5'd0);
    tick();
    chk("hadd_aluout", bus.aluout, 32'hFFFF_8000);
    chk("hadd_carry", 32'(bus.carry), 32'd0);
    chk("hadd_ovf", 32'(bus.overflow), 32'd0);
    issue(1'b1, 1'b0, 3'b001, 3'd7, 32'h0, 32'h1234_ABCD, 5'd0);
    tick();
    chk("lhg_aluout", bus.aluout, 32'hABCD_0000);

    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, 3'b101, ld_op[i], 32'h0, 32'h0, 5'd0);
      tick();
      chk("load_aluout", bus.aluout, ld_exp[i]);
      chk("load_valid", 32'(bus.valid_out), 32'd1);
    end
    issue(1'b1, 1'b0, 3'b011, 3'd0, 32'h1, 32'h1, 5'd0);
    tick();
    idle();
    chk("badsel_aluout", bus.aluout, 32'h0);
    chk("badsel_valid", 32'(bus.valid_out), 32'd1);

    issue(1'b0, 1'b1, 3'b000, 3'b011, 32'h8000_0010, 32'h0, 5'd5);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("asr_stall", 32'(bus.stall_out), 32'd1);
      chk("asr_novalid", 32'(bus.valid_out), 32'd0);
      issue(1'b1, 1'b0, 3'b001, 3'd0, 32'h1111_1111, 32'h1, 5'd2);
      tick();
    end
    idle();
    chk("asr_aluout", bus.aluout, 32'hFC00_0000);
    chk("asr_carry", 32'(bus.carry), 32'd1);
    chk("asr_valid", 32'(bus.valid_out), 32'd1);
    chk("asr_stall_end", 32'(bus.stall_out), 32'd0);
    tick();
    chk("asr_single_pulse", 32'(bus.valid_out), 32'd0);

    issue(1'b0, 1'b1, 3'b000, 3'b011, 32'h0000_1234, 32'h0, 5'd0);
    tick();
    idle();
    chk("n0_aluout", bus.aluout, 32'h0000_1234);
    chk("n0_valid", 32'(bus.valid_out), 32'd1);
    chk("n0_stall", 32'(bus.stall_out), 32'd0);

    issue(1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_0003, 32'h0, 5'd1);
    tick();
    idle();
    chk("lsr1_stall", 32'(bus.stall_out), 32'd1);
    tick();
    chk("lsr1_aluout", bus.aluout, 32'h0000_0001);
    chk("lsr1_carry", 32'(bus.carry), 32'd1);
    chk("lsr1_valid", 32'(bus.valid_out), 32'd1);

    issue(1'b1, 1'b1, 3'b001, 3'd0, 32'h2, 32'h3, 5'd4);
    tick();
    idle();
    chk("both_aluout", bus.aluout, 32'h5);
    chk("both_valid", 32'(bus.valid_out), 32'd1);
    chk("both_stall", 32'(bus.stall_out), 32'd0);

    issue(1'b0, 1'b1, 3'b000, 3'b000, 32'hC000_0001, 32'h0, 5'd3);
    tick();
    idle();
    chk("lsl_stall", 32'(bus.stall_out), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_aluout", bus.aluout, 32'h0);
    chk("midrst_carry", 32'(bus.carry), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    chk("midrst_valid", 32'(bus.valid_out), 32'd0);
    chk("midrst_stall", 32'(bus.stall_out), 32'd0);
    tick();
    chk("midrst_novalid", 32'(bus.valid_out), 32'd0);
    chk("midrst_idle", 32'(bus.stall_out), 32'd0);
    issue(1'b1, 1'b0, 3'b001, 3'd0, 32'h2, 32'h3, 5'd0);
    tick();
    idle();
    chk("postrst_aluout", bus.aluout, 32'h5);
    chk("postrst_valid", 32'(bus.valid_out), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
